// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   DATA_BITS     : payload bits per 8N1 frame
//   CLKS_PER_BIT  : clocks per bit at the default 100 MHz / 115200 baud
//   clks_per_bit  : clocks per bit for any clock/baud pair (integer-truncated)
//   rx_state_t    : receiver FSM states
package uart_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CLKS_PER_BIT = 100_000_000 / 115_200;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a head-of-queue read port.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_push, i_push_data     : write request and data (ignored when full unless popping)
//   i_pop                   : read request (ignored when empty)
//   o_head                  : entry at the read pointer
//   o_full, o_empty, o_count: occupancy status
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small receive FIFO read through valid/ready.
//   clk, reset   : system clock, asynchronous active-low reset
//   rx           : serial input, idle high, asynchronous to clk
//   rd_data      : head-of-FIFO byte, meaningful while rd_valid=1
//   rd_valid     : FIFO not empty
//   rd_ready     : consumer accepts rd_data on a rising edge with rd_valid=1
//   frame_err    : one-cycle pulse when a stop bit samples low
//   overrun      : sticky, a byte was dropped on a full FIFO
//   clr_overrun  : synchronous clear of overrun (a same-cycle overrun wins)
//   count        : FIFO occupancy
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned Cpb  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CntW = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntHalf = CntW'(Cpb / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Cpb - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CntW-1:0]      r_cnt;
  logic [BitW-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_rxs;
  logic w_cnt_zero;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  // Two-flop synchronizer; resets to the idle line level so no false start is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs      = r_sync2;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            // Half a bit lands the next samples at mid-bit.
            r_cnt   <= CntHalf;
            r_state <= START;
          end
        end
        START: begin
          if (w_cnt_zero) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_cnt     <= CntFull;
              r_bit_idx <= '0;
              r_state   <= DATA;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_cnt   <= CntFull;
            if (r_bit_idx == LastBit) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          if (w_cnt_zero) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WAIT_HIGH: begin
          // Holding here keeps a break from raising repeated frame errors.
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The push happens on the same edge that samples a good stop bit.
  assign w_push = (r_state == STOP) && w_cnt_zero && w_rxs;
  assign w_pop  = rd_ready && !w_empty;
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (rd_ready),
    .o_head      (rd_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (count)
  );

  assign rd_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized phase,
// compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;

  localparam int unsigned ClkFreq = 100_000_000;
  localparam int unsigned Baud    = 1_000_000;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Cpb     = ClkFreq / Baud;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_model[$];
  logic       ovr_model;
  int         fe_model;
  int         fe_seen = 0;

  uart_rx_fifo #(
    .CLK_FREQ   (ClkFreq),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .count       (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":count"}, 32'(count), 32'(q_model.size()));
    check({tag, ":rd_valid"}, 32'(rd_valid), 32'(q_model.size() != 0));
    if (q_model.size() != 0) check({tag, ":rd_data"}, 32'(rd_data), 32'(q_model[0]));
    check({tag, ":overrun"}, 32'(overrun), 32'(ovr_model));
    check({tag, ":frame_errs"}, 32'(fe_seen), 32'(fe_model));
  endtask

  task automatic bits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Full frame; a low stop bit is held for low_bits bit times before the line idles.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int low_bits);
    bits(1'b0, Cpb);
    for (int i = 0; i < 8; i++) bits(b[i], Cpb);
    if (stop) bits(1'b1, Cpb);
    else bits(1'b0, Cpb * low_bits);
    bits(1'b1, 2 * Cpb);
    if (!stop) fe_model++;
    else if (q_model.size() < Depth) q_model.push_back(b);
    else ovr_model = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    check({tag, ":pop_valid"}, 32'(rd_valid), 32'd1);
    check({tag, ":pop_data"}, 32'(rd_data), 32'(q_model[0]));
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    void'(q_model.pop_front());
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    ovr_model = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b0;
    rx = 1'b1;
    rd_ready = 1'b0;
    clr_overrun = 1'b0;
    ovr_model = 1'b0;
    fe_model = 0;
    repeat (4) @(negedge clk);
    check("reset:rd_data", 32'(rd_data), 32'd0);
    check_state("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame, consumer not ready.
    send_frame(8'hAA, 1'b1, 0);
    check_state("aa");

    // Back-to-back frames then drain.
    send_frame(8'h55, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    check_state("55_0f");
    pop_one("drain_aa");
    pop_one("drain_55");
    pop_one("drain_0f");
    check_state("drained");

    // Short low glitch on an idle line must not start a frame.
    bits(1'b0, Cpb * 3 / 10);
    bits(1'b1, 2 * Cpb);
    check_state("glitch");
    send_frame(8'h3C, 1'b1, 0);
    check_state("3c");
    pop_one("read_3c");

    // Bad stop bit, then a break of five bit times: exactly one frame error.
    send_frame(8'h99, 1'b0, 1);
    check_state("stop_low");
    send_frame(8'h00, 1'b0, 5);
    check_state("break");
    send_frame(8'h81, 1'b1, 0);
    check_state("81");
    pop_one("read_81");

    // Overflow a full FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    check_state("overflow");
    for (int i = 0; i < 4; i++) pop_one("overflow_read");
    check_state("overflow_drained");
    pulse_clr();
    check_state("clr_overrun");

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h11, 1'b1, 0);
    b = 8'h5A;
    bits(1'b0, Cpb);
    for (int i = 0; i < 4; i++) bits(b[i], Cpb);
    bits(b[4], Cpb / 2);
    #2 reset = 1'b0;
    rx = 1'b1;
    q_model.delete();
    ovr_model = 1'b0;
    repeat (3) @(negedge clk);
    check_state("mid_reset");
    reset = 1'b1;
    bits(1'b1, Cpb);
    check_state("after_reset");
    send_frame(8'hC3, 1'b1, 0);
    check_state("c3");
    pop_one("read_c3");

    // Randomized traffic against the queue model.
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r < 6) send_frame(b, (r != 0), 1);
      else if (r < 9 && q_model.size() != 0) pop_one("rand_pop");
      else pulse_clr();
      check_state("rand");
    end
    while (q_model.size() != 0) pop_one("final_drain");
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the Patmos UART: the receiving end of the frames a bench or host drives onto io_uartPins_rx.
- Samples 8N1 serial data at mid-bit, validates the start and stop bits, and pushes bytes into a small FIFO.
- The core reads bytes through a valid/ready handshake.
- Reports framing errors and FIFO overrun.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; 868 at the defaults.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: 0 = reset asserted.
- rx  in  1  serial input, idle high, asynchronous to clk.
- rd_data  out  8  head-of-FIFO byte; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts rd_data when rd_valid and rd_ready are both 1 at a rising edge.
- frame_err  out  1  one-cycle pulse when a stop bit samples 0.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- clr_overrun  in  1  synchronous clear of overrun.
- count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - Synchronizer flops are set to 1.
  - State = IDLE, FIFO empty.
  - rd_valid=0, rd_data=0, frame_err=0, overrun=0, count=0.
- Synchronization: rx passes through a 2-flop synchronizer. rxs below means the synchronized value; rx is never used directly.
- States:
  - IDLE: when rxs=0, load the counter with CLKS_PER_BIT/2 - 1 and go to START.
  - START: when the counter reaches 0, sample rxs.
    - rxs=1: glitch, return to IDLE with no output.
    - rxs=0: reload the counter with CLKS_PER_BIT-1, set bit index to 0, go to DATA.
  - DATA: each time the counter reaches 0, shift rxs into the shift register LSB-first and reload the counter. After bit 7 is sampled, go to STOP.
  - STOP: when the counter reaches 0, sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: pulse frame_err for one cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Push:
  - Occurs on the edge that samples the stop bit.
  - rd_valid rises on the next cycle when the FIFO was empty.
  - Latency from the rx stop-bit midpoint to rd_valid: 3 cycles (2 synchronizer + 1).
- FIFO full at push: byte dropped, overrun set to 1, FIFO contents unchanged.
- Simultaneous push and pop:
  - Allowed at any occupancy. When full, pop-then-push applies: no overrun, count unchanged.
  - When empty, no pop occurs (rd_valid=0) and the push proceeds.
- Overrun flag:
  - clr_overrun clears overrun.
  - If clr_overrun and a new overrun occur in the same cycle, set wins.
- rd_data is driven from the registered head entry. When empty it holds the last value, which is don't-care.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is kept separately and saturates at neither bound in normal operation.
- Reset mid-frame: all state is discarded immediately; the partial byte is never pushed.
- The counter is wide enough for CLKS_PER_BIT-1; no other arithmetic is involved.

Decomposition:
- Package uart_pkg holds:
  - Constant CLKS_PER_BIT (function of CLK_FREQ/BAUD).
  - Enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - DATA_BITS=8.
- One sub-module, sync_fifo: parameterized width/depth, with push, pop, full, empty and count.
- The receiver FSM and the synchronizer stay in uart_rx_fifo.

Test Plan:
- Frame 0xAA: start 0, bits 0,1,0,1,0,1,0,1, stop 1, at 8681 ns/bit with a 100 MHz clk, rd_ready=0 → rd_valid=1, rd_data=0xAA, count=1, frame_err never pulses.
- 0x55 then 0x0F back-to-back, then rd_ready held 1 → rd_data reads 0x55 then 0x0F, count returns to 0, rd_valid=0.
- 3 µs low glitch on idle rx → no push, state back to IDLE, count=0; a following valid 0x3C is received correctly.
- Frame with stop bit 0 → frame_err pulses exactly once, count unchanged. Line held low for 5 bit times → no second pulse. After rx returns high, the next frame 0x81 is received.
- 5 frames 0x01..0x05 with rd_ready=0 and FIFO_DEPTH=4 → count=4, overrun=1; reads return 0x01..0x04. clr_overrun for one cycle → overrun=0.
- reset driven to 0 during DATA bit 4 of a frame, released, then frame 0xC3 sent → count=0 after reset, only 0xC3 received, no frame_err.
